// File: rtl/nonce_gen_if.sv
// Handshake and status bundle between the nonce generator and its Curl loader.
// The slave side is the generator; the master side drives seeds and control.
interface nonce_gen_if #(
  parameter int CNT_W = 32
);
  logic             i_start;
  logic             i_stop;
  logic [53:0]      i_rnd_trits;
  logic             i_ready;
  logic [53:0]      o_nonce;
  logic             o_valid;
  logic             o_busy;
  logic [CNT_W-1:0] o_count;
  logic             o_wrap;

  modport master (
    output i_start, i_stop, i_rnd_trits, i_ready,
    input  o_nonce, o_valid, o_busy, o_count, o_wrap
  );

  modport slave (
    input  i_start, i_stop, i_rnd_trits, i_ready,
    output o_nonce, o_valid, o_busy, o_count, o_wrap
  );
endinterface

// File: rtl/nonce_gen.sv
// Balanced-ternary nonce generator: seeds a 27-trit nonce from a random trit
// source and presents successive +1 increments to the Curl loader.
module nonce_gen #(
  parameter int CNT_W = 32
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  nonce_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_xfer;
  logic [54:0]      w_inc;

  logic [53:0]      r_nonce;
  logic             r_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic             r_wrap;

  // The illegal trit code 2'b10 is folded to zero so only legal trits circulate.
  function automatic logic [53:0] sanitise(input logic [53:0] t);
    logic [53:0] r;
    r = t;
    for (int k = 0; k < 27; k++) begin
      if (t[2*k+:2] == 2'b10) r[2*k+:2] = 2'b00;
    end
    return r;
  endfunction

  // Returns {carry_out, nonce + 1}; carry ripples across all 27 trits.
  function automatic logic [54:0] bt_inc(input logic [53:0] n);
    logic [53:0] r;
    logic        c;
    r = n;
    c = 1'b1;
    for (int k = 0; k < 27; k++) begin
      if (c) begin
        case (n[2*k+:2])
          2'b00:   begin r[2*k+:2] = 2'b01; c = 1'b0; end
          2'b01:   begin r[2*k+:2] = 2'b11; c = 1'b1; end
          default: begin r[2*k+:2] = 2'b00; c = 1'b0; end
        endcase
      end
    end
    return {c, r};
  endfunction

  assign w_inc = bt_inc(r_nonce);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start && !bus.i_stop) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (bus.i_stop) begin
          w_state_nxt = IDLE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_stop)       w_state_nxt = IDLE;
        else if (bus.i_start) w_state_nxt = LOAD;
        else                  w_xfer      = r_valid && bus.i_ready;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Status flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_nonce <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == ISSUE);
      r_busy  <= (w_state_nxt != IDLE);
      if (w_load) begin
        r_nonce <= sanitise(bus.i_rnd_trits);
        r_count <= '0;
        r_wrap  <= 1'b0;
      end else if (w_xfer) begin
        r_nonce <= w_inc[53:0];
        r_count <= r_count + CNT_W'(1);
        if (w_inc[54]) r_wrap <= 1'b1;
      end
    end
  end

  assign bus.o_nonce = r_nonce;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = r_busy;
  assign bus.o_count = r_count;
  assign bus.o_wrap  = r_wrap;

endmodule

// File: doc/nonce_gen.md
NONCE_GEN -- requirements
Module: nonce_gen

Interface
REQ-001 Parameter: CNT_W, default 32, width of the issued-nonce counter o_count.
REQ-002 Reset i_arst_n, asynchronous, active-low; clock i_clk.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_arst_n  input  1  asynchronous active-low reset.
REQ-005 i_start  input  1  pulse; capture seed and begin issuing nonces.
REQ-006 i_stop  input  1  pulse; cease issuing and return to idle.
REQ-007 i_rnd_trits  input  54  27 random trits from the LFSR trit source, 2 bits per trit, trit k = bits [2k+1:2k].
REQ-008 i_ready  input  1  downstream Curl loader accepts o_nonce this cycle.
REQ-009 o_nonce  output  54  current nonce, 27 trits, same encoding.
REQ-010 o_valid  output  1  o_nonce is valid for transfer.
REQ-011 o_busy  output  1  block is not in IDLE.
REQ-012 o_count  output  CNT_W  number of nonces accepted since last start.
REQ-013 o_wrap  output  1  sticky; nonce space wrapped since last start.

Function
REQ-014 Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1; 2'b10 is illegal and is mapped to 2'b00 on capture.
REQ-015 FSM states: IDLE, LOAD, ISSUE; reset state IDLE.
REQ-016 IDLE -> LOAD when i_start=1; otherwise stay; o_valid=0.
REQ-017 LOAD (one cycle): o_nonce <= sanitised i_rnd_trits, o_count <= 0, o_wrap <= 0; next state ISSUE.
REQ-018 ISSUE: o_valid=1; transfer occurs on a cycle with o_valid=1 and i_ready=1.
REQ-019 On transfer: o_nonce <= o_nonce + 1 in balanced ternary, o_count <= o_count + 1 (modulo 2^CNT_W); new nonce is presented the next cycle (one nonce per cycle at full throughput).
REQ-020 Balanced-ternary +1 per trit starting at trit 0: 0 -> +1 no carry; +1 -> -1 carry; -1 -> 0 no carry; carry propagates trit 0 to 26 within one cycle.
REQ-021 Carry out of trit 26: o_nonce becomes all -1 (all 2'b11), o_wrap <= 1; issuing continues.
REQ-022 o_nonce and o_valid SHALL hold stable while o_valid=1 and i_ready=0.
REQ-023 i_stop=1 in LOAD or ISSUE -> IDLE next cycle, no transfer counted that cycle even if i_ready=1; o_nonce, o_count, o_wrap retain last values.
REQ-024 i_start and i_stop both 1 in IDLE: i_stop wins, stay IDLE.
REQ-025 i_start=1 in ISSUE (without i_stop): -> LOAD (reseed); no transfer counted that cycle.
REQ-026 o_busy=1 in LOAD and ISSUE, 0 in IDLE.
REQ-027 Outputs are registered; no combinational path from i_ready to o_valid or o_nonce.

Reset
REQ-028 i_arst_n low: state IDLE, o_nonce=0, o_valid=0, o_busy=0, o_count=0, o_wrap=0, immediately and independent of i_clk.
REQ-029 Reset asserted mid-ISSUE aborts without any further transfer; after release block waits in IDLE for i_start.

Verification
REQ-030 Seed all trits 0 (54'h0), start, i_ready=1 for 4 cycles -> accepted nonces trit0..1 = 0, +1, (-1,+1), (0,+1); o_count=4.
REQ-031 Seed with trit 5 = 2'b10, others 0 -> first o_nonce = 54'h0.
REQ-032 Seed all +1 (every pair 01), one transfer -> o_nonce all 2'b11, o_wrap=1, o_count=1.
REQ-033 i_ready toggled 1,0,0,1 in ISSUE -> exactly 2 increments, o_nonce stable during stall cycles.
REQ-034 i_stop with i_ready=1 in ISSUE -> o_valid=0 next cycle, o_count unchanged; i_start then reloads and clears o_count, o_wrap.
REQ-035 Assert i_arst_n low mid-ISSUE -> all outputs zero same cycle, IDLE after release.
